io_command_scheduler: RTL and testbench
=======================================

# io_command_scheduler

Shares one IO issue port from the core across PORTCOUNT IO command controllers and merges their writeback streams back onto the single register-writeback bus. Commands are steered by a port-select field through a one-entry registered slot. Writebacks are merged by a lock-until-accepted round-robin arbiter with a registered output. The block sits between the IO issue stage and the per-port command controllers, all on sys_clk.

## Interface
- PORTCOUNT, 4: number of attached command controllers (≥2).
- DATABITWIDTH, 16: width of address, data and writeback data.
- PORTSELBITWIDTH, $clog2(PORTCOUNT): port-select width.
- WATCHDOGCYCLES, 255: command-slot stall limit; used only with the watchdog macro.
- sys_clk  in  1  single clock, rising edge.
- async_rst_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  global clock enable; when low, all state holds and all handshake outputs are 0.
- IssueACK  in  1  issue command valid.
- IssueREQ  out  1  scheduler can accept.
- IssuePortSel  in  PORTSELBITWIDTH  target port.
- MinorOpcodeIn  in  4  minor opcode.
- CommandAddressIn  in  DATABITWIDTH  address offset.
- CommandDataIn  in  DATABITWIDTH  store data.
- CommandDestReg  in  4  destination register.
- PortCommandACK  out  PORTCOUNT  one-hot command valid per port.
- PortCommandREQ  in  PORTCOUNT  per-port ready.
- PortMinorOpcode / PortAddress / PortData / PortDestReg  out  4 / DATABITWIDTH / DATABITWIDTH / 4  registered slot contents, shared by all ports.
- PortWritebackACK  in  PORTCOUNT  per-port writeback valid.
- PortWritebackREQ  out  PORTCOUNT  one-hot grant/ready.
- PortWritebackDestReg  in  PORTCOUNT×4.
- PortWritebackData  in  PORTCOUNT×DATABITWIDTH.
- WritebackACK  out  1  merged writeback valid.
- WritebackREQ  in  1  writeback bus ready.
- WritebackDestReg  out  4.
- WritebackDataOut  out  DATABITWIDTH.
- BadPortPulse  out  1  one-cycle pulse when a command targeting IssuePortSel ≥ PORTCOUNT is discarded.

## Operation
- Transfer rule: a transfer occurs on any cycle where ACK && REQ && clk_en. The producer drives ACK; the consumer drives REQ.
- Command slot states: EMPTY, FULL.
  - IssueREQ = clk_en && (EMPTY || PortCommandREQ[slot port]).
  - An issue transfer in EMPTY, or in FULL while the slot drains, loads the slot and latches the port index.
  - PortCommandACK[i] = FULL && slot port == i && clk_en.
  - A port transfer with no simultaneous issue transfer returns the slot to EMPTY.
- Out-of-range port select: the command is accepted, it is not loaded, and BadPortPulse is high the next cycle.
- Writeback arbiter states: IDLE, HOLD.
  - In IDLE, or in HOLD while WritebackREQ is high: if any PortWritebackACK is set, pick the first requesting port at or after rr_ptr (wrapping).
  - Assert PortWritebackREQ for the winner in that same cycle and capture its dest/data into the output register.
  - Set rr_ptr to winner+1 mod PORTCOUNT and enter or stay in HOLD.
- HOLD: WritebackACK = 1 and the output register is stable until WritebackREQ. Then go to IDLE if nothing new was captured.
- Ports that lose arbitration keep ACK asserted and are not granted. At most one PortWritebackREQ bit is high per cycle.

## Timing
- Issue → PortCommandACK: 1 cycle. Full throughput of 1 command/cycle when the target port is continuously ready.
- PortWritebackACK → WritebackACK: 1 cycle. Back-to-back writebacks sustain 1/cycle.
- Under reset, all outputs are 0: IssueREQ, PortCommandACK, PortWritebackREQ, WritebackACK, data/dest outputs, BadPortPulse.
- Reset also clears rr_ptr to 0, puts the slot in EMPTY and the arbiter in IDLE.
- IssueREQ rises the first clk_en cycle after reset deassertion.
- Reset mid-operation drops any held command and any held writeback without handshake completion.
- clk_en low freezes both FSMs, rr_ptr and the watchdog counter.

## Configuration
- IOSCHED_WATCHDOG_EN defined:
  - A counter tracks the cycles the slot is FULL without a port transfer.
  - On reaching WATCHDOGCYCLES, the slot is forced EMPTY (command discarded).
  - Sticky output PortFault[PORTCOUNT-1:0] sets the bit of the stalled port. Sticky bits clear only on reset.
  - The counter resets on every slot load or drain.
- Undefined: no counter and no PortFault port; a stalled port blocks issue indefinitely.

## Structure
- Shared package io_pkg holds:
  - typedef io_command_t: opcode[3:0], addr, data, dest[3:0].
  - typedef io_writeback_t: dest[3:0], data.
  - IO_DESTREG_WIDTH = 4.
- Sub-module io_rr_arbiter: parameterised PORTCOUNT. Inputs are the request vector and rr_ptr; outputs are the one-hot grant and the winner index. Purely combinational; pointer register stays in the parent.

## Test plan
- Issue port 2, data 0x1234, port 2 ready → PortCommandACK = 4'b0100 next cycle with PortData = 0x1234; IssueREQ stays 1.
- Port 1 holds PortCommandREQ = 0 for 5 cycles with a second issue pending → IssueREQ = 0 for those cycles; both commands are delivered in order once ready.
- PortWritebackACK = 4'b1111 continuously with WritebackREQ = 1 → grants in order 0,1,2,3,0 with WritebackDestReg matching each port's dest.
- WritebackREQ held 0 for 3 cycles → WritebackACK/data stable, no further PortWritebackREQ; grant resumes at rr_ptr afterwards.
- IssuePortSel = 5 with PORTCOUNT = 4 → accepted, no PortCommandACK, BadPortPulse high for exactly 1 cycle.
- With IOSCHED_WATCHDOG_EN and WATCHDOGCYCLES = 8, port 3 never ready → slot discarded after 8 cycles, PortFault = 4'b1000, IssueREQ returns to 1.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared command/writeback types and FSM encodings for the IO scheduler
package io_pkg;

   localparam int IO_DESTREG_WIDTH = 4;
   localparam int IO_OPCODE_WIDTH  = 4;
   localparam int IO_DATA_WIDTH    = 16;

   typedef struct packed {
      logic [IO_OPCODE_WIDTH-1:0]  opcode;
      logic [IO_DATA_WIDTH-1:0]    addr;
      logic [IO_DATA_WIDTH-1:0]    data;
      logic [IO_DESTREG_WIDTH-1:0] dest;
   } io_command_t;

   typedef struct packed {
      logic [IO_DESTREG_WIDTH-1:0] dest;
      logic [IO_DATA_WIDTH-1:0]    data;
   } io_writeback_t;

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t;

endpackage

// File: rtl/io_rr_arbiter.sv
// rtl/io_rr_arbiter.sv - combinational round-robin pick starting at a caller-held pointer
module io_rr_arbiter #(
   parameter int PORTCOUNT = 4,
   parameter int IDXW      = $clog2(PORTCOUNT)
) (
   input  logic [PORTCOUNT-1:0] req,
   input  logic [IDXW-1:0]      ptr,
   output logic [PORTCOUNT-1:0] grant,
   output logic [IDXW-1:0]      winner
);

   logic            found;
   logic [IDXW-1:0] idx;

   // walk the ports from ptr upward (wrapping) and grant the first requester
   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < PORTCOUNT; k++) begin
         idx = IDXW'((int'(ptr) + k) % PORTCOUNT);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            winner     = idx;
         end
      end
   end

endmodule

// File: rtl/io_command_scheduler.sv
// rtl/io_command_scheduler.sv - IO issue steering slot and writeback merge; optional IOSCHED_WATCHDOG_EN slot watchdog
module io_command_scheduler
   import io_pkg::*;
#(
   parameter int PORTCOUNT       = 4,
   parameter int DATABITWIDTH    = 16,
   parameter int PORTSELBITWIDTH = $clog2(PORTCOUNT),
   parameter int WATCHDOGCYCLES  = 255
) (
   input  logic                                  sys_clk,
   input  logic                                  async_rst_n,
   input  logic                                  clk_en,
   input  logic                                  IssueACK,
   output logic                                  IssueREQ,
   input  logic [PORTSELBITWIDTH-1:0]            IssuePortSel,
   input  logic [3:0]                            MinorOpcodeIn,
   input  logic [DATABITWIDTH-1:0]               CommandAddressIn,
   input  logic [DATABITWIDTH-1:0]               CommandDataIn,
   input  logic [3:0]                            CommandDestReg,
   output logic [PORTCOUNT-1:0]                  PortCommandACK,
   input  logic [PORTCOUNT-1:0]                  PortCommandREQ,
   output logic [3:0]                            PortMinorOpcode,
   output logic [DATABITWIDTH-1:0]               PortAddress,
   output logic [DATABITWIDTH-1:0]               PortData,
   output logic [3:0]                            PortDestReg,
   input  logic [PORTCOUNT-1:0]                  PortWritebackACK,
   output logic [PORTCOUNT-1:0]                  PortWritebackREQ,
   input  logic [PORTCOUNT*4-1:0]                PortWritebackDestReg,
   input  logic [PORTCOUNT*DATABITWIDTH-1:0]     PortWritebackData,
   output logic                                  WritebackACK,
   input  logic                                  WritebackREQ,
   output logic [3:0]                            WritebackDestReg,
   output logic [DATABITWIDTH-1:0]               WritebackDataOut,
   output logic                                  BadPortPulse
`ifdef IOSCHED_WATCHDOG_EN
   ,
   output logic [PORTCOUNT-1:0]                  PortFault
`endif
);

   localparam int IDXW = $clog2(PORTCOUNT);

   if (PORTCOUNT < 2) begin : g_chk_portcount
      $error("PORTCOUNT must be at least 2");
   end
   if (DATABITWIDTH != IO_DATA_WIDTH) begin : g_chk_width
      $error("DATABITWIDTH must match io_pkg::IO_DATA_WIDTH");
   end
   if (PORTSELBITWIDTH < IDXW) begin : g_chk_sel
      $error("PORTSELBITWIDTH too narrow for PORTCOUNT");
   end
   if (WATCHDOGCYCLES < 1) begin : g_chk_wd
      $error("WATCHDOGCYCLES must be at least 1");
   end

   // nothing moves while clk_en is low or reset is asserted
   logic active;
   assign active = clk_en && async_rst_n;

   slot_state_t            slot_state_q, slot_state_d;
   logic [PORTCOUNT-1:0]   port_oh_q, port_oh_d;
   io_command_t            cmd_q, cmd_d;
   logic                   bad_q, bad_d;
   logic [PORTCOUNT-1:0]   sel_oh;
   logic                   sel_ok, port_ready, issue_req, issue_xfer, port_xfer, slot_drop;

   arb_state_t             arb_state_q, arb_state_d;
   logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
   io_writeback_t          wb_q, wb_d;
   logic [PORTCOUNT-1:0]   arb_grant;
   logic [IDXW-1:0]        arb_winner;
   logic                   arb_open;

   // decode the port select; an out-of-range select decodes to no port
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < PORTCOUNT; i++) begin
         if (IssuePortSel == PORTSELBITWIDTH'(i)) sel_oh[i] = 1'b1;
      end
   end

   assign sel_ok     = |sel_oh;
   assign port_ready = |(port_oh_q & PortCommandREQ);
   assign issue_req  = active && ((slot_state_q == SLOT_EMPTY) || port_ready);
   assign issue_xfer = IssueACK && issue_req;
   assign port_xfer  = active && (slot_state_q == SLOT_FULL) && port_ready;

`ifdef IOSCHED_WATCHDOG_EN
   localparam int WDW = $clog2(WATCHDOGCYCLES + 1);
   logic [WDW-1:0]       wd_q, wd_d;
   logic [PORTCOUNT-1:0] fault_q, fault_d;
   logic                 wd_timeout;

   // count stalled FULL cycles; on the limit drop the command and flag the port
   always_comb begin
      wd_d       = wd_q;
      fault_d    = fault_q;
      wd_timeout = 1'b0;
      if (active) begin
         if ((slot_state_q == SLOT_EMPTY) || port_xfer || issue_xfer) begin
            wd_d = '0;
         end else if (wd_q == WDW'(WATCHDOGCYCLES - 1)) begin
            wd_timeout = 1'b1;
            wd_d       = '0;
            fault_d    = fault_q | port_oh_q;
         end else begin
            wd_d = wd_q + WDW'(1);
         end
      end
   end

   // watchdog counter and sticky fault flags
   always_ff @(posedge sys_clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         wd_q    <= '0;
         fault_q <= '0;
      end else begin
         wd_q    <= wd_d;
         fault_q <= fault_d;
      end
   end

   assign slot_drop = wd_timeout;
   assign PortFault = fault_q;
`else
   assign slot_drop = 1'b0;
`endif

   // command slot: load on accepted in-range issue, empty on drain or watchdog drop
   always_comb begin
      slot_state_d = slot_state_q;
      port_oh_d    = port_oh_q;
      cmd_d        = cmd_q;
      bad_d        = bad_q;
      if (active) begin
         bad_d = issue_xfer && !sel_ok;
         if (issue_xfer && sel_ok) begin
            slot_state_d = SLOT_FULL;
            port_oh_d    = sel_oh;
            cmd_d.opcode = MinorOpcodeIn;
            cmd_d.addr   = CommandAddressIn;
            cmd_d.data   = CommandDataIn;
            cmd_d.dest   = CommandDestReg;
         end else if (port_xfer || slot_drop) begin
            slot_state_d = SLOT_EMPTY;
         end
      end
   end

   io_rr_arbiter #(.PORTCOUNT(PORTCOUNT), .IDXW(IDXW)) u_rr_arbiter (
      .req    (PortWritebackACK),
      .ptr    (rr_ptr_q),
      .grant  (arb_grant),
      .winner (arb_winner)
   );

   assign arb_open = active && ((arb_state_q == ARB_IDLE) || WritebackREQ);

   // writeback merge: grant and capture when the output register is free or draining
   always_comb begin
      arb_state_d      = arb_state_q;
      rr_ptr_d         = rr_ptr_q;
      wb_d             = wb_q;
      PortWritebackREQ = '0;
      if (arb_open) begin
         if (|PortWritebackACK) begin
            PortWritebackREQ = arb_grant;
            wb_d             = '0;
            for (int i = 0; i < PORTCOUNT; i++) begin
               if (arb_grant[i]) begin
                  wb_d.dest = PortWritebackDestReg[i*IO_DESTREG_WIDTH +: IO_DESTREG_WIDTH];
                  wb_d.data = PortWritebackData[i*DATABITWIDTH +: DATABITWIDTH];
               end
            end
            rr_ptr_d    = (arb_winner == IDXW'(PORTCOUNT - 1)) ? '0 : arb_winner + IDXW'(1);
            arb_state_d = ARB_HOLD;
         end else begin
            arb_state_d = ARB_IDLE;
         end
      end
   end

   // state registers for slot, arbiter, pointer and bad-port pulse
   always_ff @(posedge sys_clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         slot_state_q <= SLOT_EMPTY;
         port_oh_q    <= '0;
         cmd_q        <= '0;
         bad_q        <= 1'b0;
         arb_state_q  <= ARB_IDLE;
         rr_ptr_q     <= '0;
         wb_q         <= '0;
      end else begin
         slot_state_q <= slot_state_d;
         port_oh_q    <= port_oh_d;
         cmd_q        <= cmd_d;
         bad_q        <= bad_d;
         arb_state_q  <= arb_state_d;
         rr_ptr_q     <= rr_ptr_d;
         wb_q         <= wb_d;
      end
   end

   assign IssueREQ         = issue_req;
   assign PortCommandACK   = (active && (slot_state_q == SLOT_FULL)) ? port_oh_q : '0;
   assign PortMinorOpcode  = cmd_q.opcode;
   assign PortAddress      = cmd_q.addr;
   assign PortData         = cmd_q.data;
   assign PortDestReg      = cmd_q.dest;
   assign WritebackACK     = active && (arb_state_q == ARB_HOLD);
   assign WritebackDestReg = wb_q.dest;
   assign WritebackDataOut = wb_q.data;
   assign BadPortPulse     = active && bad_q;

endmodule

// File: tb/tb_io_command_scheduler.sv
// tb/tb_io_command_scheduler.sv - scoreboard bench for io_command_scheduler
`timescale 1ns/1ps
module tb_io_command_scheduler;

   localparam int PC  = 4;
   localparam int DW  = 16;
   localparam int PSW = 3;
   localparam int WDC = 8;

   logic              sys_clk = 1'b0;
   logic              async_rst_n = 1'b1;
   logic              clk_en = 1'b0;
   logic              IssueACK = 1'b0;
   logic              IssueREQ;
   logic [PSW-1:0]    IssuePortSel = '0;
   logic [3:0]        MinorOpcodeIn = '0;
   logic [DW-1:0]     CommandAddressIn = '0;
   logic [DW-1:0]     CommandDataIn = '0;
   logic [3:0]        CommandDestReg = '0;
   logic [PC-1:0]     PortCommandACK;
   logic [PC-1:0]     PortCommandREQ = '0;
   logic [3:0]        PortMinorOpcode;
   logic [DW-1:0]     PortAddress;
   logic [DW-1:0]     PortData;
   logic [3:0]        PortDestReg;
   logic [PC-1:0]     PortWritebackACK = '0;
   logic [PC-1:0]     PortWritebackREQ;
   logic [PC*4-1:0]   PortWritebackDestReg = {4'hB, 4'hA, 4'h9, 4'h8};
   logic [PC*DW-1:0]  PortWritebackData = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
   logic              WritebackACK;
   logic              WritebackREQ = 1'b0;
   logic [3:0]        WritebackDestReg;
   logic [DW-1:0]     WritebackDataOut;
   logic              BadPortPulse;
`ifdef IOSCHED_WATCHDOG_EN
   logic [PC-1:0]     PortFault;
`endif

   always #5 sys_clk = ~sys_clk;

   io_command_scheduler #(
      .PORTCOUNT(PC), .DATABITWIDTH(DW), .PORTSELBITWIDTH(PSW), .WATCHDOGCYCLES(WDC)
   ) dut (
      .sys_clk(sys_clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
      .IssueACK(IssueACK), .IssueREQ(IssueREQ), .IssuePortSel(IssuePortSel),
      .MinorOpcodeIn(MinorOpcodeIn), .CommandAddressIn(CommandAddressIn),
      .CommandDataIn(CommandDataIn), .CommandDestReg(CommandDestReg),
      .PortCommandACK(PortCommandACK), .PortCommandREQ(PortCommandREQ),
      .PortMinorOpcode(PortMinorOpcode), .PortAddress(PortAddress),
      .PortData(PortData), .PortDestReg(PortDestReg),
      .PortWritebackACK(PortWritebackACK), .PortWritebackREQ(PortWritebackREQ),
      .PortWritebackDestReg(PortWritebackDestReg), .PortWritebackData(PortWritebackData),
      .WritebackACK(WritebackACK), .WritebackREQ(WritebackREQ),
      .WritebackDestReg(WritebackDestReg), .WritebackDataOut(WritebackDataOut),
      .BadPortPulse(BadPortPulse)
`ifdef IOSCHED_WATCHDOG_EN
      , .PortFault(PortFault)
`endif
   );

   typedef struct {
      logic [PC-1:0] oh;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    op;
      logic [3:0]    dest;
   } cmd_exp_t;

   cmd_exp_t      exp_cmd[$];
   logic [PC-1:0] exp_grant[$];
   logic [19:0]   exp_wb[$];
   cmd_exp_t      mc;
   logic [19:0]   mw;
   logic [PC-1:0] mg;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic samp();
      @(negedge sys_clk);
   endtask

   task automatic issue(input int p, input logic [DW-1:0] d, input bit deliver);
      cmd_exp_t ce;
      IssueACK         = 1'b1;
      IssuePortSel     = PSW'(p);
      CommandDataIn    = d;
      CommandAddressIn = d ^ 16'h5A5A;
      MinorOpcodeIn    = 4'(p + 3);
      CommandDestReg   = d[3:0];
      if (deliver) begin
         ce.oh   = PC'(1 << p);
         ce.data = d;
         ce.addr = d ^ 16'h5A5A;
         ce.op   = 4'(p + 3);
         ce.dest = d[3:0];
         exp_cmd.push_back(ce);
      end
   endtask

   task automatic expect_wb(input int p);
      exp_grant.push_back(PC'(1 << p));
      exp_wb.push_back({4'(8 + p), 16'hD000 + 16'(p)});
   endtask

   // command delivery monitor
   always @(negedge sys_clk) begin
      check("cmd_onehot", 32'($countones(PortCommandACK) <= 1), 1);
      if ((PortCommandACK & PortCommandREQ) != '0) begin
         if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", 32'(PortCommandACK), 0);
         end else begin
            mc = exp_cmd.pop_front();
            check("cmd_port", 32'(PortCommandACK), 32'(mc.oh));
            check("cmd_data", 32'(PortData), 32'(mc.data));
            check("cmd_addr", 32'(PortAddress), 32'(mc.addr));
            check("cmd_op", 32'(PortMinorOpcode), 32'(mc.op));
            check("cmd_dest", 32'(PortDestReg), 32'(mc.dest));
         end
      end
   end

   // writeback grant and merged output monitor
   always @(negedge sys_clk) begin
      check("wb_grant_onehot", 32'($countones(PortWritebackREQ) <= 1), 1);
      if (PortWritebackREQ != '0) begin
         if (exp_grant.size() == 0) begin
            check("wb_grant_unexpected", 32'(PortWritebackREQ), 0);
         end else begin
            mg = exp_grant.pop_front();
            check("wb_grant", 32'(PortWritebackREQ), 32'(mg));
         end
      end
      if (WritebackACK && WritebackREQ) begin
         if (exp_wb.size() == 0) begin
            check("wb_unexpected", 32'({WritebackDestReg, WritebackDataOut}), 0);
         end else begin
            mw = exp_wb.pop_front();
            check("wb_dest", 32'(WritebackDestReg), 32'(mw[19:16]));
            check("wb_data", 32'(WritebackDataOut), 32'(mw[15:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int stall_cycles;
      bit done;

      // reset with live requests on every input
      #2 async_rst_n = 1'b0;
      clk_en           = 1'b1;
      PortCommandREQ   = 4'b1111;
      PortWritebackACK = 4'b1111;
      IssueACK         = 1'b1;
      WritebackREQ     = 1'b1;
      samp();
      samp();
      check("rst_issuereq", 32'(IssueREQ), 0);
      check("rst_cmdack", 32'(PortCommandACK), 0);
      check("rst_wbreq", 32'(PortWritebackREQ), 0);
      check("rst_wback", 32'(WritebackACK), 0);
      check("rst_wbdata", 32'(WritebackDataOut), 0);
      check("rst_wbdest", 32'(WritebackDestReg), 0);
      check("rst_portdata", 32'(PortData), 0);
      check("rst_bad", 32'(BadPortPulse), 0);
`ifdef IOSCHED_WATCHDOG_EN
      check("rst_fault", 32'(PortFault), 0);
`endif
      IssueACK         = 1'b0;
      PortWritebackACK = '0;
      WritebackREQ     = 1'b0;
      tick();
      async_rst_n = 1'b1;
      samp();
      check("post_rst_issuereq", 32'(IssueREQ), 1);
      tick();

      // single command to port 2
      issue(2, 16'h1234, 1'b1);
      samp();
      check("t1_issuereq_pre", 32'(IssueREQ), 1);
      tick();
      IssueACK = 1'b0;
      samp();
      check("t1_cmdack", 32'(PortCommandACK), 4'b0100);
      check("t1_portdata", 32'(PortData), 16'h1234);
      check("t1_issuereq", 32'(IssueREQ), 1);
      tick();

      // back-to-back commands, one per cycle
      for (int p = 0; p < PC; p++) begin
         issue(p, 16'h2000 + 16'(p * 17), 1'b1);
         samp();
         check("tput_issuereq", 32'(IssueREQ), 1);
         tick();
      end
      IssueACK = 1'b0;
      tick();

      // port 1 stalls with a second command pending
      PortCommandREQ = 4'b1101;
      issue(1, 16'h00A1, 1'b1);
      samp();
      tick();
      issue(1, 16'h00B2, 1'b1);
      for (int c = 0; c < 5; c++) begin
         samp();
         check("stall_issuereq", 32'(IssueREQ), 0);
         check("stall_cmdack", 32'(PortCommandACK), 4'b0010);
         tick();
      end
      PortCommandREQ = 4'b1111;
      samp();
      check("release_issuereq", 32'(IssueREQ), 1);
      tick();
      IssueACK = 1'b0;
      samp();
      tick();

      // out-of-range port select
      issue(5, 16'h0BAD, 1'b0);
      samp();
      check("bad_issuereq", 32'(IssueREQ), 1);
      tick();
      IssueACK = 1'b0;
      samp();
      check("bad_pulse_hi", 32'(BadPortPulse), 1);
      check("bad_no_cmdack", 32'(PortCommandACK), 0);
      tick();
      samp();
      check("bad_pulse_lo", 32'(BadPortPulse), 0);
      check("bad_no_cmdack2", 32'(PortCommandACK), 0);
      tick();

      // clock enable freezes the slot and blanks handshakes
      PortCommandREQ = 4'b0111;
      issue(3, 16'h3C3C, 1'b1);
      samp();
      tick();
      IssueACK = 1'b0;
      samp();
      check("cen_cmdack_on", 32'(PortCommandACK), 4'b1000);
      tick();
      clk_en = 1'b0;
      samp();
      check("cen_cmdack_off", 32'(PortCommandACK), 0);
      check("cen_issuereq", 32'(IssueREQ), 0);
      tick();
      tick();
      clk_en = 1'b1;
      PortCommandREQ = 4'b1111;
      samp();
      tick();

      // all ports request writeback continuously
      WritebackREQ     = 1'b1;
      PortWritebackACK = 4'b1111;
      expect_wb(0);
      expect_wb(1);
      expect_wb(2);
      expect_wb(3);
      expect_wb(0);
      for (int k = 0; k < 5; k++) begin
         samp();
         tick();
      end
      PortWritebackACK = '0;
      samp();
      tick();
      samp();
      check("wb_idle_after_burst", 32'(WritebackACK), 0);
      tick();

      // writeback bus backpressure holds the output register
      WritebackREQ     = 1'b0;
      PortWritebackACK = 4'b0101;
      expect_wb(2);
      samp();
      tick();
      for (int c = 0; c < 3; c++) begin
         samp();
         check("bp_wback", 32'(WritebackACK), 1);
         check("bp_dest", 32'(WritebackDestReg), 4'hA);
         check("bp_data", 32'(WritebackDataOut), 16'hD002);
         check("bp_no_grant", 32'(PortWritebackREQ), 0);
         tick();
      end
      WritebackREQ = 1'b1;
      expect_wb(0);
      samp();
      tick();
      PortWritebackACK = '0;
      samp();
      tick();
      samp();
      check("bp_idle", 32'(WritebackACK), 0);
      tick();

`ifdef IOSCHED_WATCHDOG_EN
      // port 3 never ready: watchdog drops the command
      PortCommandREQ = 4'b0111;
      issue(3, 16'h0DEA, 1'b0);
      samp();
      tick();
      IssueACK = 1'b0;
      stall_cycles = 0;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         samp();
         if (!done) begin
            if (PortCommandACK == 4'b1000) stall_cycles++;
            else done = 1'b1;
         end
         tick();
      end
      check("wd_stall_cycles", 32'(stall_cycles), WDC);
      check("wd_fault", 32'(PortFault), 4'b1000);
      check("wd_issuereq", 32'(IssueREQ), 1);
      PortCommandREQ = 4'b1111;
`else
      stall_cycles = 0;
      done = 1'b0;
`endif

      repeat (3) tick();
      check("cmd_queue_drained", 32'(exp_cmd.size()), 0);
      check("grant_queue_drained", 32'(exp_grant.size()), 0);
      check("wb_queue_drained", 32'(exp_wb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
